// File: rtl/mure_pkg.sv
// Shared types for the MURE trace connector: the retired-uop record that
// travels from the CVA6 commit ports through the retirement group FIFO.
package mure_pkg;

    typedef enum logic [1:0] {
        NOP    = 2'd0,
        STD    = 2'd1,
        EXC    = 2'd2,
        BRANCH = 2'd3
    } itype_e;

    typedef struct packed {
        itype_e      itype;
        logic [31:0] pc;
        logic [31:0] tval;
    } uop_entry_s;

endpackage

// File: rtl/retire_group_fifo.sv
// Retirement group FIFO: samples the commit ports every cycle, left-justifies
// the valid lanes into one group, and queues groups in a circular buffer whose
// head is presented to the ingress FSM. Groups that arrive while the buffer is
// full (and the head is not being taken) are dropped, counted and flagged.
module retire_group_fifo #(
    parameter int unsigned NrRetiredInstr = 4,
    parameter int unsigned Depth          = 4,
    parameter int unsigned DropCntW       = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NrRetiredInstr-1:0]   commit_valid_i,
    input  mure_pkg::uop_entry_s        commit_uop_a_i,
    input  mure_pkg::uop_entry_s        commit_uop_b_i,
    input  mure_pkg::uop_entry_s        commit_uop_c_i,
    input  mure_pkg::uop_entry_s        commit_uop_d_i,
    input  logic                        flush_i,
    input  logic                        clear_ovf_i,
    input  logic                        pop_i,
    output logic                        valid_o,
    output logic [NrRetiredInstr-1:0]   ivalids_o,
    output mure_pkg::uop_entry_s        uop_a_o,
    output mure_pkg::uop_entry_s        uop_b_o,
    output mure_pkg::uop_entry_s        uop_c_o,
    output mure_pkg::uop_entry_s        uop_d_o,
    output logic                        full_o,
    output logic [$clog2(Depth):0]      count_o,
    output logic                        overflow_o,
    output logic [DropCntW-1:0]         drop_cnt_o
);

    localparam int unsigned PtrW   = $clog2(Depth);
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned MaxLns = 4;

    // One stored group: packed valid mask plus four lanes, uops[0] = lane A.
    typedef struct packed {
        logic [NrRetiredInstr-1:0]           mask;
        mure_pkg::uop_entry_s [MaxLns-1:0]   uops;
    } group_t;

    // Input-side lanes, padded to four with lane A in valid_pad[3].
    mure_pkg::uop_entry_s raw_uop [MaxLns];
    logic [MaxLns-1:0]    valid_pad;
    logic [2:0]           n_valid;
    logic [MaxLns-1:0]    mask_pad;
    group_t               packed_grp;

    // Buffer state.
    group_t               mem_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q;
    logic [PtrW-1:0]      rd_ptr_q;
    logic [CntW-1:0]      count_q;
    logic                 overflow_q;
    logic [DropCntW-1:0]  drop_cnt_q;

    // Handshake decisions for this cycle.
    logic                 push_req;
    logic                 pop_acc;
    logic                 push_acc;
    logic                 drop;
    logic                 full;
    group_t               head;

    assign raw_uop[0] = commit_uop_a_i;
    assign raw_uop[1] = (NrRetiredInstr > 1) ? commit_uop_b_i : '0;
    assign raw_uop[2] = (NrRetiredInstr > 2) ? commit_uop_c_i : '0;
    assign raw_uop[3] = (NrRetiredInstr > 3) ? commit_uop_d_i : '0;

    // Lanes beyond NrRetiredInstr read as invalid.
    assign valid_pad = 4'(commit_valid_i) << (MaxLns - NrRetiredInstr);

    // Compact valid lanes toward lane A, keeping their original order.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        packed_grp = '0;
        n_valid    = '0;
        for (int i = 0; i < MaxLns; i++) begin
            if (valid_pad[MaxLns-1-i]) begin
                packed_grp.uops[n_valid[1:0]] = raw_uop[i];
                n_valid = n_valid + 3'd1;
            end
        end
        mask_pad        = ~(4'hF >> n_valid);
        packed_grp.mask = mask_pad[MaxLns-1 -: NrRetiredInstr];
    end

    assign full     = (count_q == CntW'(Depth));
    assign valid_o  = (count_q != '0);
    assign push_req = |commit_valid_i;
    assign pop_acc  = pop_i && valid_o;
    // A full buffer still accepts when the head leaves in the same cycle.
    assign push_acc = push_req && !flush_i && (!full || pop_acc);
    assign drop     = push_req && !flush_i && full && !pop_acc;

    // Pointer and occupancy bookkeeping; flush empties the buffer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_acc) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_acc)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push_acc, pop_acc})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter; a same-cycle drop beats a clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (clear_ovf_i)            drop_cnt_q <= DropCntW'(1);
            else if (drop_cnt_q != '1)  drop_cnt_q <= drop_cnt_q + DropCntW'(1);
        end else if (clear_ovf_i) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end
    end

    // Group storage write at the write pointer.
    always_ff @(posedge clk_i) begin
        // NOTE: the data array is not reset; outputs are gated by valid_o so stale entries never show.
        if (push_acc) mem_q[wr_ptr_q] <= packed_grp;
    end

    assign head       = mem_q[rd_ptr_q];
    assign ivalids_o  = valid_o ? head.mask    : '0;
    assign uop_a_o    = valid_o ? head.uops[0] : '0;
    assign uop_b_o    = valid_o ? head.uops[1] : '0;
    assign uop_c_o    = valid_o ? head.uops[2] : '0;
    assign uop_d_o    = valid_o ? head.uops[3] : '0;
    assign full_o     = full;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule
